// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter
//   Round-robin arbiter sharing one slave port of the cross-bar between
//   NUM_MASTERS requesters on the req/ack bus. One master owns the port for
//   a whole transaction (including the read-data return cycle). Priority
//   rotates after every completed, timed-out or aborted transaction.
//   A watchdog ends transactions the slave never acknowledges.
//
// Ports
//   clk, reset                : clock, async active-high reset
//   m_req/m_addr/m_cmd/m_wdata: per-master request side (32-bit slices)
//   m_ack/m_rdata             : per-master response side
//   s_req/s_addr/s_cmd/s_wdata: to the slave
//   s_ack/s_rdata             : from the slave (rdata valid the cycle after ack)
//   busy                      : FSM not in IDLE
//   grant_id                  : current / last granted master
//   timeout_err               : one-cycle pulse when the watchdog fires
module slave_port_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]    m_cmd,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [32*NUM_MASTERS-1:0] m_rdata,
    output logic                      s_req,
    output logic [31:0]               s_addr,
    output logic                      s_cmd,
    output logic [31:0]               s_wdata,
    input  logic                      s_ack,
    input  logic [31:0]               s_rdata,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic                      timeout_err
);

    // Keep the counter at least one bit wide when the watchdog is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RDATA} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;     // current read ended by the watchdog

    // Signals of the granted master
    logic          g_req, g_cmd;
    logic [31:0]   g_addr, g_wdata;

    logic          in_grant, wd_fire, ack_grant;
    logic [31:0]   rdata_src;
    logic [2:0]    ptr_adv;
    logic          found;
    logic [2:0]    winner;

    always_comb begin
        g_req   = 1'b0;
        g_cmd   = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gid_q == 3'(i)) begin
                g_req   = m_req[i];
                g_cmd   = m_cmd[i];
                g_addr  = m_addr[32*i +: 32];
                g_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    // Round-robin search: offset i from ptr, first requesting master wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!found && m_req[j] && ((int'(ptr_q) + i) % NUM_MASTERS == j)) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    assign in_grant  = (state_q == GRANT);
    // An aborting master (req dropped) gets no ack, so the watchdog is gated by g_req.
    assign wd_fire   = (TIMEOUT != 0) && in_grant && g_req && !s_ack
                       && (cnt_q == CW'(TIMEOUT));
    assign ack_grant = in_grant && g_req && (s_ack || wd_fire);
    assign rdata_src = err_q ? ERR_DATA : s_rdata;
    assign ptr_adv   = (gid_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : gid_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (found) begin
                    gid_d   = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!g_req) begin
                    state_d = IDLE;
                    ptr_d   = ptr_adv;
                end else if (s_ack) begin
                    state_d = g_cmd ? IDLE : RDATA;
                    ptr_d   = ptr_adv;
                end else if (wd_fire) begin
                    state_d = g_cmd ? IDLE : RDATA;
                    err_d   = 1'b1;
                    ptr_d   = ptr_adv;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign s_req       = in_grant && g_req && !wd_fire;
    assign s_addr      = in_grant ? g_addr  : 32'd0;
    assign s_cmd       = in_grant && g_cmd;
    assign s_wdata     = in_grant ? g_wdata : 32'd0;
    assign busy        = (state_q != IDLE);
    assign grant_id    = gid_q;
    assign timeout_err = wd_fire;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        logic sel;
        assign sel                = (gid_q == 3'(i));
        assign m_ack[i]           = sel && ack_grant;
        assign m_rdata[32*i +: 32] = (sel && state_q == RDATA) ? rdata_src : 32'd0;
    end

endmodule
